// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT/DIV family done 34 edges after start; MTHI/MTLO done the cycle after the write.
// Backpressure: start is honoured only in IDLE; while busy, requests are dropped.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state, next_state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    a;       // multiplicand magnitude, or raw dividend for divide-by-zero
    logic [WIDTH-1:0]    b;       // divisor magnitude
    logic [2*WIDTH-1:0]  acc;     // {partial product, multiplier} or {remainder, quotient}
    logic                neg_res;
    logic                neg_rem;
    logic                is_div;
    logic                div0;
    logic                done_r;

    logic                op_mul, op_div, op_mthi, op_mtlo, is_signed;
    logic                last_step;
    logic [WIDTH-1:0]    mag1, mag2;
    logic [WIDTH:0]      msum;
    logic [WIDTH:0]      dshift, ddiff;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quot_fix, rem_fix;

    assign last_step = (cnt == CW'(WIDTH-1));

    always_comb begin
        next_state = state;
        op_mul     = 1'b0;
        op_div     = 1'b0;
        op_mthi    = 1'b0;
        op_mtlo    = 1'b0;
        is_signed  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT:  begin op_mul = 1'b1; is_signed = 1'b1; next_state = MUL; end
                        F_MULTU: begin op_mul = 1'b1; next_state = MUL; end
                        F_DIV:   begin op_div = 1'b1; is_signed = 1'b1; next_state = DIV; end
                        F_DIVU:  begin op_div = 1'b1; next_state = DIV; end
                        F_MTHI:  op_mthi = 1'b1;
                        F_MTLO:  op_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL:     if (last_step) next_state = FIX;
            DIV:     if (last_step) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    assign mag1 = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2 = (is_signed && in2[WIDTH-1]) ? -in2 : in2;

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set.
    assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a : {WIDTH{1'b0}})};

    // Restoring divide: remainder < divisor, so the shifted value fits in WIDTH+1 bits.
    assign dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, b};

    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            div0    <= 1'b0;
            done_r  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done_r <= 1'b0;
            if (op_mul || op_div) begin
                cnt     <= '0;
                neg_res <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                neg_rem <= is_signed & in1[WIDTH-1];
                is_div  <= op_div;
                div0    <= (in2 == '0);
                b       <= mag2;
                if (op_mul) begin
                    a   <= mag1;
                    acc <= {{WIDTH{1'b0}}, mag2};
                end else begin
                    a   <= in1;
                    acc <= {{WIDTH{1'b0}}, mag1};
                end
            end
            if (op_mthi) begin
                hi     <= in1;
                done_r <= 1'b1;
            end
            if (op_mtlo) begin
                lo     <= in1;
                done_r <= 1'b1;
            end
            case (state)
                MUL: begin
                    acc <= {msum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    if (ddiff[WIDTH])
                        acc <= {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    else
                        acc <= {ddiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    done_r <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div0) begin
                        hi <= a;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, handshake, signed/unsigned results, corner cases.
// Latency: n/a. Backpressure: n/a.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_mul_div_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for done; returns at the done cycle.
    task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                         output int edges, output int busy_cycles);
        start = 1'b1;
        funct = f;
        in1   = x;
        in2   = y;
        @(posedge clk); #1;
        start       = 1'b0;
        edges       = 1;
        busy_cycles = 0;
        while (!done && edges < 60) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        in1   = '0;
        in2   = '0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mult_signed;
        int e, b;
        do_op(F_MULT, 32'hFFFFFFFD, 32'd7, e, b);
        checks++;
        if (e !== 34) begin errors++; $display("FAIL mult_latency got %0d required 34", e); end
        checks++;
        if (b !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d required 33", b); end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mult_neg hi=%h lo=%h required FFFFFFFF FFFFFFEB", hi, lo);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %b required 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b required 0", done); end
    endtask

    task automatic test_mult_extremes;
        int e, b;
        do_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, e, b);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++;
            $display("FAIL multu_max hi=%h lo=%h required FFFFFFFE 00000001", hi, lo);
        end
        @(posedge clk); #1;
        do_op(F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, e, b);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h1) begin
            errors++;
            $display("FAIL mult_m1_m1 hi=%h lo=%h required 00000000 00000001", hi, lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div;
        int e, b;
        do_op(F_DIV, 32'hFFFFFFF9, 32'd2, e, b);
        checks++;
        if (e !== 34) begin errors++; $display("FAIL div_latency got %0d required 34", e); end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_neg hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi, lo);
        end
        @(posedge clk); #1;
        do_op(F_DIVU, 32'd100, 32'd7, e, b);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL divu_100_7 hi=%h lo=%h required 00000002 0000000e", hi, lo);
        end
        @(posedge clk); #1;
        do_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, e, b);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h80000000) begin
            errors++;
            $display("FAIL div_overflow hi=%h lo=%h required 00000000 80000000", hi, lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero;
        int e, b, pulses;
        do_op(F_DIVU, 32'd100, 32'd0, e, b);
        checks++;
        if (e !== 34) begin errors++; $display("FAIL divzero_latency got %0d required 34", e); end
        checks++;
        if (hi !== 32'd100 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL divzero_result hi=%h lo=%h required 00000064 FFFFFFFF", hi, lo);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL divzero_extra_done got %0d required 0", pulses); end
        do_op(F_DIV, 32'hFFFFFFF9, 32'd0, e, b);
        checks++;
        if (hi !== 32'hFFFFFFF9 || lo !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL divzero_signed hi=%h lo=%h required FFFFFFF9 FFFFFFFF", hi, lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore_and_mt;
        int e, busy_seen;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; funct = F_MULT; in1 = 32'd6; in2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        e = 1;
        while (!done && e < 60) begin
            if (e == 5) begin
                start = 1'b1; funct = F_DIV; in1 = 32'd100; in2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (e == 10) begin
                checks++;
                if (hi !== prev_hi || lo !== prev_lo) begin
                    errors++;
                    $display("FAIL hold_mid_op hi=%h lo=%h required %h %h", hi, lo, prev_hi, prev_lo);
                end
            end
            @(posedge clk); #1;
            e++;
        end
        start = 1'b0;
        checks++;
        if (e !== 34) begin errors++; $display("FAIL ignore_latency got %0d required 34", e); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            errors++;
            $display("FAIL ignore_result hi=%h lo=%h required 00000000 0000002a", hi, lo);
        end
        @(posedge clk); #1;
        start = 1'b1; funct = F_MTHI; in1 = 32'h1234;
        busy_seen = 0;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) busy_seen++;
        checks++;
        if (hi !== 32'h1234 || lo !== 32'd42 || done !== 1'b1) begin
            errors++;
            $display("FAIL mthi hi=%h lo=%h done=%b required 00001234 0000002a 1", hi, lo, done);
        end
        @(posedge clk); #1;
        if (busy) busy_seen++;
        checks++;
        if (done !== 1'b0 || busy_seen !== 0) begin
            errors++;
            $display("FAIL mthi_handshake done=%b busy_seen=%0d required 0 0", done, busy_seen);
        end
        start = 1'b1; funct = F_MTLO; in1 = 32'hBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (lo !== 32'hBEEF || hi !== 32'h1234 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo hi=%h lo=%h done=%b busy=%b required 00001234 0000beef 1 0", hi, lo, done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_funct;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = hi;
        prev_lo = lo;
        start = 1'b1; funct = 6'b100000; in1 = 32'h5555; in2 = 32'h3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== prev_hi || lo !== prev_lo) begin
            errors++;
            $display("FAIL illegal_funct busy=%b done=%b hi=%h lo=%h required 0 0 %h %h",
                     busy, done, hi, lo, prev_hi, prev_lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int e, b;
        do_op(F_DIVU, 32'd100, 32'd7, e, b);
        // Issued on the done cycle of the previous operation.
        do_op(F_MULTU, 32'h00010000, 32'h00010000, e, b);
        checks++;
        if (e !== 34) begin errors++; $display("FAIL b2b_latency got %0d required 34", e); end
        checks++;
        if (hi !== 32'd1 || lo !== 32'd0) begin
            errors++;
            $display("FAIL b2b_result hi=%h lo=%h required 00000001 00000000", hi, lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        int e, b, done_seen;
        start = 1'b1; funct = F_MULT; in1 = 32'd9; in2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL async_reset busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        done_seen = 0;
        @(posedge clk); #1;
        if (done) done_seen++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_discard activity=%0d hi=%h lo=%h required 0 0 0", done_seen, hi, lo);
        end
        do_op(F_MULT, 32'd5, 32'd5, e, b);
        checks++;
        if (e !== 34 || hi !== 32'd0 || lo !== 32'd25) begin
            errors++;
            $display("FAIL post_reset_mult edges=%0d hi=%h lo=%h required 34 00000000 00000019", e, hi, lo);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_mult_signed;
        test_mult_extremes;
        test_div;
        test_div_zero;
        test_busy_ignore_and_mt;
        test_illegal_funct;
        test_back_to_back;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
